// File: rtl/pong_pkg.sv
// Shared encodings and widths for the pong match controller.
package pong_pkg;

   localparam int unsigned STATE_W     = 3;
   localparam int unsigned SCORE_W     = 4;
   localparam int unsigned TICK_CNT_W  = 16;
   localparam int unsigned SERVE_CNT_W = 8;

   typedef enum logic [STATE_W-1:0] {
      ST_IDLE   = 3'd0,
      ST_SERVE  = 3'd1,
      ST_PLAY   = 3'd2,
      ST_SCORED = 3'd3,
      ST_OVER   = 3'd4
   } state_e;

   typedef enum logic [1:0] {
      WIN_NONE = 2'b00,
      WIN_P1   = 2'b01,
      WIN_P2   = 2'b10
   } winner_e;

endpackage

// File: rtl/pong_tick_gen.sv
// Game tick generator: one-cycle pulse every DIV cycles, restartable via clr.
// The pulse is registered and lands in the DIV-th cycle after a clear, so
// anything acting on it takes effect DIV cycles after the clear.
module pong_tick_gen #(
   parameter int unsigned DIV = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   output logic tick
);
   import pong_pkg::*;

   logic [TICK_CNT_W-1:0] r_cnt;
   logic                  r_tick;

   // Free-running modulo-DIV counter with a look-ahead registered pulse.
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         r_cnt  <= '0;
         r_tick <= 1'b0;
      end else begin
         r_tick <= (r_cnt == TICK_CNT_W'(DIV - 2));
         if (r_cnt == TICK_CNT_W'(DIV - 1)) begin
            r_cnt <= '0;
         end else begin
            r_cnt <= r_cnt + TICK_CNT_W'(1);
         end
      end
   end

   assign tick = r_tick;

endmodule

// File: rtl/pong_match_ctrl.sv
// Pong match controller: sequences serve/play/score/game-over and keeps score.
module pong_match_ctrl
   import pong_pkg::*;
#(
   parameter int unsigned TICK_DIV    = 16,
   parameter int unsigned WIN_SCORE   = 7,
   parameter int unsigned SERVE_TICKS = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start_btn,
   input  logic       point_1,
   input  logic       point_2,
   output logic       game_start,
   output logic       game_rst,
   output logic       step_en,
   output logic       serve_r,
   output logic [3:0] score_1,
   output logic [3:0] score_2,
   output logic       gameover,
   output logic [1:0] winner,
   output logic [2:0] ctrl_state
);

   state_e                 r_state;
   state_e                 w_next;

   logic                   r_start_q;
   logic                   r_p1_q;
   logic                   r_p2_q;
   logic                   w_start_rise;
   logic                   w_p1_rise;
   logic                   w_p2_rise;

   logic                   w_tick;
   logic                   w_clr;

   logic [SERVE_CNT_W-1:0] r_serve_cnt;
   logic [SERVE_CNT_W-1:0] w_serve_cnt_d;

   logic                   r_game_start, w_game_start_d;
   logic                   r_game_rst,   w_game_rst_d;
   logic                   r_step_en,    w_step_en_d;
   logic                   r_serve_r,    w_serve_r_d;
   logic                   r_gameover,   w_gameover_d;
   logic [SCORE_W-1:0]     r_score_1,    w_score_1_d;
   logic [SCORE_W-1:0]     r_score_2,    w_score_2_d;
   winner_e                r_winner,     w_winner_d;

   // Tick counter restarts on every state change.
   pong_tick_gen #(
      .DIV (TICK_DIV)
   ) u_tick_gen (
      .clk  (clk),
      .rst  (rst),
      .clr  (w_clr),
      .tick (w_tick)
   );

   // Edge-detect history; loads during reset so held inputs give no edge later.
   always_ff @(posedge clk) begin
      r_start_q <= start_btn;
      r_p1_q    <= point_1;
      r_p2_q    <= point_2;
   end

   assign w_start_rise = start_btn & ~r_start_q;
   assign w_p1_rise    = point_1   & ~r_p1_q;
   assign w_p2_rise    = point_2   & ~r_p2_q;

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Next-state and next-output logic.
   always_comb begin
      w_next         = r_state;
      w_serve_cnt_d  = r_serve_cnt;
      w_game_start_d = 1'b0;
      w_game_rst_d   = 1'b0;
      w_serve_r_d    = r_serve_r;
      w_score_1_d    = r_score_1;
      w_score_2_d    = r_score_2;
      w_winner_d     = r_winner;

      case (r_state)
         ST_IDLE, ST_OVER: begin
            if (w_start_rise) begin
               w_next       = ST_SERVE;
               w_score_1_d  = '0;
               w_score_2_d  = '0;
               w_winner_d   = WIN_NONE;
               w_game_rst_d = 1'b1;
            end
         end
         ST_SERVE: begin
            if (w_tick) begin
               if (r_serve_cnt == SERVE_CNT_W'(SERVE_TICKS - 1)) begin
                  w_next         = ST_PLAY;
                  w_game_start_d = 1'b1;
               end else begin
                  w_serve_cnt_d = r_serve_cnt + SERVE_CNT_W'(1);
               end
            end
         end
         ST_PLAY: begin
            if (w_p1_rise && w_p2_rise) begin
               w_serve_r_d  = ~r_serve_r;
               w_next       = ST_SCORED;
               w_game_rst_d = 1'b1;
            end else if (w_p1_rise) begin
               if (r_score_1 < SCORE_W'(WIN_SCORE)) begin
                  w_score_1_d = r_score_1 + SCORE_W'(1);
               end
               w_serve_r_d  = 1'b0;
               w_next       = ST_SCORED;
               w_game_rst_d = 1'b1;
            end else if (w_p2_rise) begin
               if (r_score_2 < SCORE_W'(WIN_SCORE)) begin
                  w_score_2_d = r_score_2 + SCORE_W'(1);
               end
               w_serve_r_d  = 1'b1;
               w_next       = ST_SCORED;
               w_game_rst_d = 1'b1;
            end
         end
         ST_SCORED: begin
            if (r_score_1 == SCORE_W'(WIN_SCORE)) begin
               w_next     = ST_OVER;
               w_winner_d = WIN_P1;
            end else if (r_score_2 == SCORE_W'(WIN_SCORE)) begin
               w_next     = ST_OVER;
               w_winner_d = WIN_P2;
            end else begin
               w_next = ST_SERVE;
            end
         end
         default: begin
            w_next = ST_IDLE;
         end
      endcase

      w_clr = (w_next != r_state);
      if (w_clr) begin
         w_serve_cnt_d = '0;
      end
      // Suppress the step when PLAY is being left on this tick.
      w_step_en_d  = w_tick && (r_state == ST_PLAY) && (w_next == ST_PLAY);
      w_gameover_d = (w_next == ST_OVER);
   end

   // Registered outputs and serve counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_serve_cnt  <= '0;
         r_game_start <= 1'b0;
         r_game_rst   <= 1'b0;
         r_step_en    <= 1'b0;
         r_serve_r    <= 1'b1;
         r_gameover   <= 1'b0;
         r_score_1    <= '0;
         r_score_2    <= '0;
         r_winner     <= WIN_NONE;
      end else begin
         r_serve_cnt  <= w_serve_cnt_d;
         r_game_start <= w_game_start_d;
         r_game_rst   <= w_game_rst_d;
         r_step_en    <= w_step_en_d;
         r_serve_r    <= w_serve_r_d;
         r_gameover   <= w_gameover_d;
         r_score_1    <= w_score_1_d;
         r_score_2    <= w_score_2_d;
         r_winner     <= w_winner_d;
      end
   end

   assign game_start = r_game_start;
   assign game_rst   = r_game_rst;
   assign step_en    = r_step_en;
   assign serve_r    = r_serve_r;
   assign score_1    = r_score_1;
   assign score_2    = r_score_2;
   assign gameover   = r_gameover;
   assign winner     = r_winner;
   assign ctrl_state = r_state;

endmodule
